// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: writeback source codes, special register
// numbers and default datapath geometry.
package mips_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    localparam logic [1:0] WB_SRC_ALU = 2'b00;
    localparam logic [1:0] WB_SRC_MEM = 2'b01;
    localparam logic [1:0] WB_SRC_PC  = 2'b10;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd31;

endpackage : mips_pkg

// File: rtl/wb_reg_file_if.sv
// Bundle between mem_wb / ID stage and the writeback + register file block.
interface wb_reg_file_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              w_reg_ctl_in;
    logic [1:0]        mem_to_reg_in;
    logic [DATA_W-1:0] mem_data_in;
    logic [DATA_W-1:0] alu_result_in;
    logic [DATA_W-1:0] pc_value_in;
    logic [ADDR_W-1:0] w_reg_addr_in;
    logic [ADDR_W-1:0] r_addr_a;
    logic [ADDR_W-1:0] r_addr_b;
    logic [DATA_W-1:0] r_data_a;
    logic [DATA_W-1:0] r_data_b;
    logic [DATA_W-1:0] wb_data_out;
    logic              wb_en_out;

    modport master (
        output w_reg_ctl_in, mem_to_reg_in, mem_data_in, alu_result_in,
               pc_value_in, w_reg_addr_in, r_addr_a, r_addr_b,
        input  r_data_a, r_data_b, wb_data_out, wb_en_out
    );

    modport slave (
        input  w_reg_ctl_in, mem_to_reg_in, mem_data_in, alu_result_in,
               pc_value_in, w_reg_addr_in, r_addr_a, r_addr_b,
        output r_data_a, r_data_b, wb_data_out, wb_en_out
    );
endinterface : wb_reg_file_if

// File: rtl/wb_reg_file_mux.sv
// Combinational writeback source selector; also reused by the forwarding unit.
module wb_mux
    import mips_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [1:0]        mem_to_reg,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W-1:0] pc_value,
    output logic [DATA_W-1:0] wb_data
);

    // Select writeback source; the reserved code falls back to the ALU result
    always_comb begin
        wb_data = alu_result;
        case (mem_to_reg)
            WB_SRC_ALU: wb_data = alu_result;
            WB_SRC_MEM: wb_data = mem_data;
            WB_SRC_PC:  wb_data = pc_value;
            default:    wb_data = alu_result;
        endcase
    end

endmodule : wb_mux

// File: rtl/wb_reg_file.sv
// Writeback stage and 32-entry register file with two bypassed combinational
// read ports; register 0 is hardwired to zero.
module wb_reg_file
    import mips_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic          clk,
    input  logic          rst_n,
    wb_reg_file_if.slave  bus
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_r [NUM_REGS];
    logic [DATA_W-1:0] wb_data_s;
    logic              wb_en_s;
    logic [DATA_W-1:0] rd_a_s;
    logic [DATA_W-1:0] rd_b_s;

    wb_mux #(
        .DATA_W (DATA_W)
    ) u_wb_mux (
        .mem_to_reg (bus.mem_to_reg_in),
        .alu_result (bus.alu_result_in),
        .mem_data   (bus.mem_data_in),
        .pc_value   (bus.pc_value_in),
        .wb_data    (wb_data_s)
    );

    // Effective write enable; gated by reset so nothing writes or bypasses while held
    always_comb begin
        wb_en_s = 1'b0;
        if (rst_n && bus.w_reg_ctl_in && (bus.w_reg_addr_in != REG_ZERO)) begin
            wb_en_s = 1'b1;
        end else begin
            wb_en_s = 1'b0;
        end
    end

    // Register array: async clear, single write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= '0;
            end
        end else if (wb_en_s) begin
            regs_r[bus.w_reg_addr_in] <= wb_data_s;
        end
    end

    // Read ports: zero register first, then same-cycle bypass, then array
    always_comb begin
        rd_a_s = '0;
        rd_b_s = '0;
        if (bus.r_addr_a == REG_ZERO) begin
            rd_a_s = '0;
        end else if (wb_en_s && (bus.w_reg_addr_in == bus.r_addr_a)) begin
            rd_a_s = wb_data_s;
        end else begin
            rd_a_s = regs_r[bus.r_addr_a];
        end
        if (bus.r_addr_b == REG_ZERO) begin
            rd_b_s = '0;
        end else if (wb_en_s && (bus.w_reg_addr_in == bus.r_addr_b)) begin
            rd_b_s = wb_data_s;
        end else begin
            rd_b_s = regs_r[bus.r_addr_b];
        end
    end

    assign bus.r_data_a    = rd_a_s;
    assign bus.r_data_b    = rd_b_s;
    assign bus.wb_data_out = wb_data_s;
    assign bus.wb_en_out   = wb_en_s;

endmodule : wb_reg_file

// File: tb/tb_wb_reg_file.sv
// Self-checking bench for wb_reg_file: directed vector table, reset corner
// sequence, and randomized traffic against an array-based reference model.
module tb_wb_reg_file;

    logic clk;
    logic rst_n;

    int checks;
    int failures;

    wb_reg_file_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    wb_reg_file #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ctl;
        logic [1:0]  m2r;
        logic [4:0]  wa;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [31:0] pc;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic        exp_en;
        logic [31:0] exp_wb;
        logic [31:0] exp_ra_pre;
        logic [31:0] exp_rb_pre;
        logic [31:0] exp_ra_post;
        logic [31:0] exp_rb_post;
    } vec_t;

    vec_t vecs [9];

    logic [31:0] model_regs [32];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ctl, input logic [1:0] m2r, input logic [4:0] wa,
                         input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc,
                         input logic [4:0] ra, input logic [4:0] rb);
        bus.w_reg_ctl_in  = ctl;
        bus.mem_to_reg_in = m2r;
        bus.w_reg_addr_in = wa;
        bus.alu_result_in = alu;
        bus.mem_data_in   = mem;
        bus.pc_value_in   = pc;
        bus.r_addr_a      = ra;
        bus.r_addr_b      = rb;
    endtask

    function automatic logic [31:0] ref_wb(input logic [1:0] m2r, input logic [31:0] alu,
                                            input logic [31:0] mem, input logic [31:0] pc);
        if (m2r == 2'd1) return mem;
        if (m2r == 2'd2) return pc;
        return alu;
    endfunction

    initial begin
        logic        r_ctl;
        logic [1:0]  r_m2r;
        logic [4:0]  r_wa;
        logic [4:0]  r_ra;
        logic [4:0]  r_rb;
        logic [31:0] r_alu;
        logic [31:0] r_mem;
        logic [31:0] r_pc;
        logic [31:0] e_wb;
        logic        e_en;
        logic [31:0] e_ra;
        logic [31:0] e_rb;

        checks   = 0;
        failures = 0;

        vecs[0] = '{1'b1, 2'b00, 5'd8,  32'hAAAA0001, 32'hBBBB0002, 32'h00400010, 5'd8,  5'd8,
                    1'b1, 32'hAAAA0001, 32'hAAAA0001, 32'hAAAA0001, 32'hAAAA0001, 32'hAAAA0001};
        vecs[1] = '{1'b1, 2'b01, 5'd8,  32'hAAAA0001, 32'hBBBB0002, 32'h00400010, 5'd8,  5'd9,
                    1'b1, 32'hBBBB0002, 32'hBBBB0002, 32'h0, 32'hBBBB0002, 32'h0};
        vecs[2] = '{1'b1, 2'b10, 5'd8,  32'hAAAA0001, 32'hBBBB0002, 32'h00400010, 5'd8,  5'd9,
                    1'b1, 32'h00400010, 32'h00400010, 32'h0, 32'h00400010, 32'h0};
        vecs[3] = '{1'b1, 2'b11, 5'd8,  32'hAAAA0001, 32'hBBBB0002, 32'h00400010, 5'd8,  5'd9,
                    1'b1, 32'hAAAA0001, 32'hAAAA0001, 32'h0, 32'hAAAA0001, 32'h0};
        vecs[4] = '{1'b1, 2'b00, 5'd0,  32'hFFFFFFFF, 32'hBBBB0002, 32'h00400010, 5'd0,  5'd8,
                    1'b0, 32'hFFFFFFFF, 32'h0, 32'hAAAA0001, 32'h0, 32'hAAAA0001};
        vecs[5] = '{1'b1, 2'b00, 5'd3,  32'h00000011, 32'hBBBB0002, 32'h00400010, 5'd3,  5'd3,
                    1'b1, 32'h00000011, 32'h00000011, 32'h00000011, 32'h00000011, 32'h00000011};
        vecs[6] = '{1'b1, 2'b00, 5'd3,  32'h00000022, 32'hBBBB0002, 32'h00400010, 5'd3,  5'd3,
                    1'b1, 32'h00000022, 32'h00000022, 32'h00000022, 32'h00000022, 32'h00000022};
        vecs[7] = '{1'b0, 2'b00, 5'd3,  32'h00000099, 32'hBBBB0002, 32'h00400010, 5'd3,  5'd3,
                    1'b0, 32'h00000099, 32'h00000022, 32'h00000022, 32'h00000022, 32'h00000022};
        vecs[8] = '{1'b1, 2'b10, 5'd31, 32'h0, 32'h0, 32'h0040002C, 5'd3,  5'd31,
                    1'b1, 32'h0040002C, 32'h00000022, 32'h0040002C, 32'h00000022, 32'h0040002C};

        // Power-on reset: outputs defined, no enable, mux still live
        rst_n = 1'b0;
        drive(1'b1, 2'b00, 5'd5, 32'h000000AB, 32'h0, 32'h0, 5'd5, 5'd31);
        #3;
        check("por_wb_en", {31'd0, bus.wb_en_out}, 32'd0);
        check("por_wb_data", bus.wb_data_out, 32'h000000AB);
        check("por_rd_a", bus.r_data_a, 32'h0);
        check("por_rd_b", bus.r_data_b, 32'h0);
        bus.w_reg_ctl_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vector table
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            drive(vecs[i].ctl, vecs[i].m2r, vecs[i].wa, vecs[i].alu, vecs[i].mem,
                  vecs[i].pc, vecs[i].ra, vecs[i].rb);
            #1;
            check($sformatf("vec%0d_en", i), {31'd0, bus.wb_en_out}, {31'd0, vecs[i].exp_en});
            check($sformatf("vec%0d_wb", i), bus.wb_data_out, vecs[i].exp_wb);
            check($sformatf("vec%0d_ra_pre", i), bus.r_data_a, vecs[i].exp_ra_pre);
            check($sformatf("vec%0d_rb_pre", i), bus.r_data_b, vecs[i].exp_rb_pre);
            @(posedge clk);
            #1;
            bus.w_reg_ctl_in = 1'b0;
            #1;
            check($sformatf("vec%0d_ra_post", i), bus.r_data_a, vecs[i].exp_ra_post);
            check($sformatf("vec%0d_rb_post", i), bus.r_data_b, vecs[i].exp_rb_post);
        end

        // Asynchronous reset mid-cycle after writing regs[5]
        @(negedge clk);
        drive(1'b1, 2'b00, 5'd5, 32'h00001234, 32'h0, 32'h0, 5'd5, 5'd0);
        @(posedge clk);
        #1;
        bus.w_reg_ctl_in = 1'b0;
        #1;
        check("rst_pre_value", bus.r_data_a, 32'h00001234);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_async_clear", bus.r_data_a, 32'h0);
        drive(1'b1, 2'b00, 5'd5, 32'h00000055, 32'h0, 32'h0, 5'd5, 5'd5);
        #1;
        check("rst_blk_en", {31'd0, bus.wb_en_out}, 32'd0);
        check("rst_mux_live", bus.wb_data_out, 32'h00000055);
        check("rst_no_bypass_a", bus.r_data_a, 32'h0);
        check("rst_no_bypass_b", bus.r_data_b, 32'h0);
        @(posedge clk);
        @(negedge clk);
        bus.w_reg_ctl_in = 1'b0;
        #2;
        rst_n = 1'b1;
        #1;
        check("rst_edge_lost", bus.r_data_a, 32'h0);
        drive(1'b1, 2'b01, 5'd5, 32'h0, 32'h00000066, 32'h0, 5'd5, 5'd0);
        #1;
        check("rst_first_en", {31'd0, bus.wb_en_out}, 32'd1);
        @(posedge clk);
        #1;
        bus.w_reg_ctl_in = 1'b0;
        #1;
        check("rst_first_write", bus.r_data_a, 32'h00000066);

        // Fresh reset, then randomized traffic against the reference array
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < 32; k++) model_regs[k] = 32'h0;

        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            r_ctl = 1'($urandom_range(0, 3) != 0);
            r_m2r = 2'($urandom_range(0, 3));
            r_wa  = 5'($urandom_range(0, 31));
            r_alu = $urandom;
            r_mem = $urandom;
            r_pc  = $urandom;
            r_ra  = ($urandom_range(0, 3) == 0) ? r_wa : 5'($urandom_range(0, 31));
            r_rb  = ($urandom_range(0, 3) == 0) ? r_wa : 5'($urandom_range(0, 31));
            drive(r_ctl, r_m2r, r_wa, r_alu, r_mem, r_pc, r_ra, r_rb);

            e_wb = ref_wb(r_m2r, r_alu, r_mem, r_pc);
            e_en = r_ctl && (r_wa != 5'd0);
            e_ra = (r_ra == 5'd0) ? 32'h0 : ((e_en && r_wa == r_ra) ? e_wb : model_regs[r_ra]);
            e_rb = (r_rb == 5'd0) ? 32'h0 : ((e_en && r_wa == r_rb) ? e_wb : model_regs[r_rb]);
            #1;
            check("rnd_wb", bus.wb_data_out, e_wb);
            check("rnd_en", {31'd0, bus.wb_en_out}, {31'd0, e_en});
            check("rnd_rd_a", bus.r_data_a, e_ra);
            check("rnd_rd_b", bus.r_data_b, e_rb);
            @(posedge clk);
            if (e_en) model_regs[r_wa] = e_wb;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_wb_reg_file
